// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the true dual-port RAM controller.
// Contents:
//   init_state_e    - clear sequencer states
//   RDW_READ_FIRST  - read-during-write returns the pre-write word
//   RDW_WRITE_FIRST - read-during-write returns the merged post-write word
//   be_to_mask      - expands byte enables into a bit mask
//   be_merge        - merges a new word into an old word under a bit mask
package tdp_ram_pkg;

  typedef enum logic [0:0] {StClear, StReady} init_state_e;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Widest data word the helpers accept; callers cast down to their own width.
  localparam int unsigned MaxDw = 512;
  localparam int unsigned MaxBe = MaxDw / 8;

  function automatic logic [MaxDw-1:0] be_to_mask(input logic [MaxBe-1:0] be);
    logic [MaxDw-1:0] m;
    m = '0;
    for (int i = 0; i < MaxBe; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  function automatic logic [MaxDw-1:0] be_merge(input logic [MaxDw-1:0] old_word,
                                                input logic [MaxDw-1:0] new_word,
                                                input logic [MaxDw-1:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/tdp_ram_ctrl_if.sv
// One RAM access port: request (en/we/be/addr/wdata) and response (rdata/rvalid).
// Modports:
//   master - the requester (DMA, CPU, testbench)
//   slave  - the RAM controller side
interface tdp_ram_ctrl_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
);
  logic          en;
  logic          we;
  logic [DW/8-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (output en, we, be, addr, wdata, input rdata, rvalid);
  modport slave  (input en, we, be, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/tdp_ram_init_fsm.sv
// Clear sequencer: after reset or a clr pulse, walks cnt from 0 to DEPTH-1 writing the
// init word (one address per cycle), then enters READY.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart the clear sequence at address 0
//   init_busy  - clear in progress; port requests must be ignored
//   clr_we     - clear write strobe into the array write mux
//   clr_addr   - clear write address
module tdp_ram_init_fsm
  import tdp_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          init_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  init_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = StClear;
      cnt_d   = '0;
    end else if (state_q == StClear) begin
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = StReady;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign init_busy = (state_q == StClear);
  assign clr_we    = init_busy;
  assign clr_addr  = cnt_q;

endmodule

// File: rtl/tdp_ram_ctrl.sv
// True dual-port RAM controller with byte enables, read-during-write bypass,
// same-address write arbitration (port A wins) and a hardware clear sequencer.
// Ports:
//   clk, rst_n - shared clock, asynchronous active-low reset
//   clr        - restart the clear sequence
//   init_busy  - clear in progress, requests ignored
//   a, b       - access ports (tdp_ram_ctrl_if.slave)
//   collision  - both ports wrote the same address in the previous cycle
// Build option: define TDP_RAM_OUTREG_EN to add an output register stage (read latency 2).
module tdp_ram_ctrl
  import tdp_ram_pkg::*;
#(
  parameter int unsigned   DW         = 32,
  parameter int unsigned   DEPTH      = 64,
  parameter int unsigned   RDW_MODE   = 0,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          init_busy,
  tdp_ram_ctrl_if.slave a,
  tdp_ram_ctrl_if.slave b,
  output logic          collision
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic          a_in, b_in, a_wr, b_wr_raw, b_wr, a_rd, b_rd, same_wr;
  logic [AW-1:0] a_idx, b_idx;
  logic [DW-1:0] a_old, b_old, a_new, b_new, a_rword, b_rword;
  logic          a_rvalid_q, b_rvalid_q, collision_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  tdp_ram_init_fsm #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_init_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    a_in  = 32'(a.addr) < DEPTH;
    b_in  = 32'(b.addr) < DEPTH;
    // Out-of-range addresses are steered to 0 so the array is never indexed past its end.
    a_idx = a_in ? a.addr : '0;
    b_idx = b_in ? b.addr : '0;

    a_wr     = !init_busy && a.en && a.we && a_in;
    b_wr_raw = !init_busy && b.en && b.we && b_in;
    same_wr  = a_wr && b_wr_raw && (a.addr == b.addr);
    b_wr     = b_wr_raw && !same_wr;
    a_rd     = !init_busy && a.en && !a.we;
    b_rd     = !init_busy && b.en && !b.we;

    a_old = mem[a_idx];
    b_old = mem[b_idx];
    a_new = DW'(be_merge(MaxDw'(a_old), MaxDw'(a.wdata), be_to_mask(MaxBe'(a.be))));
    b_new = DW'(be_merge(MaxDw'(b_old), MaxDw'(b.wdata), be_to_mask(MaxBe'(b.be))));

    // A reader only meets a write from the other port, since a port cannot read and
    // write in the same cycle.
    a_rword = a_old;
    if (!a_in) begin
      a_rword = '0;
    end else if (RDW_MODE == RDW_WRITE_FIRST && b_wr && (b.addr == a.addr)) begin
      a_rword = b_new;
    end
    b_rword = b_old;
    if (!b_in) begin
      b_rword = '0;
    end else if (RDW_MODE == RDW_WRITE_FIRST && a_wr && (a.addr == b.addr)) begin
      b_rword = a_new;
    end
  end

  // Storage has no reset; the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else begin
      if (a_wr) mem[a_idx] <= a_new;
      if (b_wr) mem[b_idx] <= b_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      a_rvalid_q  <= a_rd;
      b_rvalid_q  <= b_rd;
      collision_q <= same_wr;
      if (a_rd) a_rdata_q <= a_rword;
      if (b_rd) b_rdata_q <= b_rword;
    end
  end

  assign collision = collision_q;

`ifdef TDP_RAM_OUTREG_EN
  logic          a_rvalid_q2, b_rvalid_q2;
  logic [DW-1:0] a_rdata_q2, b_rdata_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q2 <= 1'b0;
      b_rvalid_q2 <= 1'b0;
      a_rdata_q2  <= '0;
      b_rdata_q2  <= '0;
    end else begin
      a_rvalid_q2 <= a_rvalid_q;
      b_rvalid_q2 <= b_rvalid_q;
      a_rdata_q2  <= a_rdata_q;
      b_rdata_q2  <= b_rdata_q;
    end
  end

  assign a.rvalid = a_rvalid_q2;
  assign b.rvalid = b_rvalid_q2;
  assign a.rdata  = a_rdata_q2;
  assign b.rdata  = b_rdata_q2;
`else
  assign a.rvalid = a_rvalid_q;
  assign b.rvalid = b_rvalid_q;
  assign a.rdata  = a_rdata_q;
  assign b.rdata  = b_rdata_q;
`endif

endmodule

// File: tb/tb_tdp_ram_ctrl.sv
// Directed testbench for tdp_ram_ctrl. Two instances: dut (DEPTH 64, read-first,
// INIT 0) and dut2 (DEPTH 48, write-first, INIT 5A5A0F0F). Port index p:
// 0 = dut.a, 1 = dut.b, 2 = dut2.a, 3 = dut2.b.
module tb_tdp_ram_ctrl;

`ifdef TDP_RAM_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam logic [31:0] Init2 = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic busy, busy2, coll, coll2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tdp_ram_ctrl_if #(.DW(32), .AW(6)) ifa ();
  tdp_ram_ctrl_if #(.DW(32), .AW(6)) ifb ();
  tdp_ram_ctrl_if #(.DW(32), .AW(6)) ifa2 ();
  tdp_ram_ctrl_if #(.DW(32), .AW(6)) ifb2 ();

  tdp_ram_ctrl #(.DW(32), .DEPTH(64), .RDW_MODE(0), .INIT_VALUE(32'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .init_busy(busy),
    .a        (ifa),
    .b        (ifb),
    .collision(coll)
  );

  tdp_ram_ctrl #(.DW(32), .DEPTH(48), .RDW_MODE(1), .INIT_VALUE(Init2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .init_busy(busy2),
    .a        (ifa2),
    .b        (ifb2),
    .collision(coll2)
  );

  task automatic drv(input int p, input logic we, input logic [3:0] be,
                     input logic [5:0] addr, input logic [31:0] wd);
    case (p)
      0: begin ifa.en = 1'b1;  ifa.we = we;  ifa.be = be;  ifa.addr = addr;  ifa.wdata = wd;  end
      1: begin ifb.en = 1'b1;  ifb.we = we;  ifb.be = be;  ifb.addr = addr;  ifb.wdata = wd;  end
      2: begin ifa2.en = 1'b1; ifa2.we = we; ifa2.be = be; ifa2.addr = addr; ifa2.wdata = wd; end
      default: begin
        ifb2.en = 1'b1; ifb2.we = we; ifb2.be = be; ifb2.addr = addr; ifb2.wdata = wd;
      end
    endcase
  endtask

  task automatic idle();
    ifa.en = 1'b0;  ifa.we = 1'b0;  ifa.be = '0;  ifa.addr = '0;  ifa.wdata = '0;
    ifb.en = 1'b0;  ifb.we = 1'b0;  ifb.be = '0;  ifb.addr = '0;  ifb.wdata = '0;
    ifa2.en = 1'b0; ifa2.we = 1'b0; ifa2.be = '0; ifa2.addr = '0; ifa2.wdata = '0;
    ifb2.en = 1'b0; ifb2.we = 1'b0; ifb2.be = '0; ifb2.addr = '0; ifb2.wdata = '0;
  endtask

  function automatic logic [31:0] rd(input int p);
    case (p)
      0: return ifa.rdata;
      1: return ifb.rdata;
      2: return ifa2.rdata;
      default: return ifb2.rdata;
    endcase
  endfunction

  function automatic logic rv(input int p);
    case (p)
      0: return ifa.rvalid;
      1: return ifb.rvalid;
      2: return ifa2.rvalid;
      default: return ifb2.rvalid;
    endcase
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present the driven request for one edge, then wait out the read latency.
  task automatic issue();
    do_cycle();
    idle();
    repeat (Lat - 1) do_cycle();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, busy2, coll, coll2} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_flags: busy/busy2/coll/coll2 got %b want 1100",
               {busy, busy2, coll, coll2});
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if ({rv(p), rd(p)} !== 33'h0) begin
        errors++;
        $display("FAIL reset_port%0d: rvalid/rdata got %b/%h want 0/0", p, rv(p), rd(p));
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_init();
    int n = 0;
    int n2 = 0;
    int bad = 0;
    rst_n = 1'b1;
    drv(0, 1'b1, 4'hF, 6'd0, 32'hFFFF_FFFF);
    drv(1, 1'b0, 4'h0, 6'd0, 32'h0);
    while (busy && n < 200) begin
      if (busy2) n2++;
      n++;
      do_cycle();
      if (rv(0) || rv(1)) bad++;
    end
    idle();
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL init_busy_len: got %0d cycles want 64", n);
    end
    checks++;
    if (n2 != 48) begin
      errors++;
      $display("FAIL init_busy_len48: got %0d cycles want 48", n2);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_ignored_rvalid: got %0d rvalid cycles want 0", bad);
    end
    for (int i = 0; i < 64; i++) begin
      drv(0, 1'b0, 4'h0, 6'(i), 32'h0);
      drv(1, 1'b0, 4'h0, 6'(63 - i), 32'h0);
      if (i < 48) begin
        drv(2, 1'b0, 4'h0, 6'(i), 32'h0);
        drv(3, 1'b0, 4'h0, 6'(47 - i), 32'h0);
      end
      issue();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if ({rv(p), rd(p)} !== {1'b1, 32'h0}) begin
          errors++;
          $display("FAIL init_read p%0d i%0d: got %b/%h want 1/00000000", p, i, rv(p), rd(p));
        end
      end
      if (i < 48) begin
        for (int p = 2; p < 4; p++) begin
          checks++;
          if ({rv(p), rd(p)} !== {1'b1, Init2}) begin
            errors++;
            $display("FAIL init_read p%0d i%0d: got %b/%h want 1/%h", p, i, rv(p), rd(p), Init2);
          end
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    drv(0, 1'b1, 4'b0101, 6'd5, 32'hDEAD_BEEF);
    issue();
    checks++;
    if (rv(0) !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rvalid: got %b want 0", rv(0));
    end
    drv(0, 1'b0, 4'h0, 6'd5, 32'h0);
    drv(1, 1'b0, 4'h0, 6'd5, 32'h0);
    issue();
    checks++;
    if ({rv(0), rd(0)} !== {1'b1, 32'h00AD_00EF}) begin
      errors++;
      $display("FAIL be_merge_a: got %b/%h want 1/00ad00ef", rv(0), rd(0));
    end
    checks++;
    if ({rv(1), rd(1)} !== {1'b1, 32'h00AD_00EF}) begin
      errors++;
      $display("FAIL be_merge_b: got %b/%h want 1/00ad00ef", rv(1), rd(1));
    end
    do_cycle();
    checks++;
    if ({rv(0), rd(0)} !== {1'b0, 32'h00AD_00EF}) begin
      errors++;
      $display("FAIL rdata_hold: got %b/%h want 0/00ad00ef", rv(0), rd(0));
    end
  endtask

  task automatic test_collision();
    drv(0, 1'b1, 4'hF, 6'd9, 32'h1111_1111);
    drv(1, 1'b1, 4'hF, 6'd9, 32'h2222_2222);
    do_cycle();
    idle();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL collision_pulse: got %b want 1", coll);
    end
    do_cycle();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL collision_once: got %b want 0", coll);
    end
    drv(0, 1'b1, 4'b0001, 6'd10, 32'h1111_1111);
    drv(1, 1'b1, 4'hF, 6'd10, 32'h2222_2222);
    do_cycle();
    idle();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL collision_partial: got %b want 1", coll);
    end
    drv(0, 1'b1, 4'hF, 6'd11, 32'h0000_000A);
    drv(1, 1'b1, 4'hF, 6'd12, 32'h0000_000B);
    do_cycle();
    idle();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL collision_diff_addr: got %b want 0", coll);
    end
    drv(0, 1'b0, 4'h0, 6'd9, 32'h0);
    drv(1, 1'b0, 4'h0, 6'd9, 32'h0);
    issue();
    checks++;
    if ({rv(0), rd(0), rv(1), rd(1), coll} !== {1'b1, 32'h1111_1111, 1'b1, 32'h1111_1111, 1'b0})
    begin
      errors++;
      $display("FAIL collision_winner: got %h/%h coll %b want 11111111/11111111 coll 0",
               rd(0), rd(1), coll);
    end
    drv(0, 1'b0, 4'h0, 6'd10, 32'h0);
    drv(1, 1'b0, 4'h0, 6'd11, 32'h0);
    issue();
    checks++;
    if (rd(0) !== 32'h0000_0011) begin
      errors++;
      $display("FAIL collision_b_dropped: got %h want 00000011", rd(0));
    end
    checks++;
    if (rd(1) !== 32'h0000_000A) begin
      errors++;
      $display("FAIL dual_write_a: got %h want 0000000a", rd(1));
    end
    drv(0, 1'b0, 4'h0, 6'd12, 32'h0);
    issue();
    checks++;
    if (rd(0) !== 32'h0000_000B) begin
      errors++;
      $display("FAIL dual_write_b: got %h want 0000000b", rd(0));
    end
  endtask

  task automatic test_rdw_read_first();
    drv(0, 1'b1, 4'hF, 6'd3, 32'hAAAA_AAAA);
    issue();
    drv(0, 1'b1, 4'hF, 6'd3, 32'h5555_5555);
    drv(1, 1'b0, 4'h0, 6'd3, 32'h0);
    issue();
    checks++;
    if ({rv(1), rd(1)} !== {1'b1, 32'hAAAA_AAAA}) begin
      errors++;
      $display("FAIL rdw_rf_b: got %b/%h want 1/aaaaaaaa", rv(1), rd(1));
    end
    drv(0, 1'b0, 4'h0, 6'd3, 32'h0);
    issue();
    checks++;
    if (rd(0) !== 32'h5555_5555) begin
      errors++;
      $display("FAIL rdw_rf_after: got %h want 55555555", rd(0));
    end
    drv(0, 1'b1, 4'hF, 6'd4, 32'h1234_5678);
    issue();
    drv(1, 1'b1, 4'b0011, 6'd4, 32'hCAFE_F00D);
    drv(0, 1'b0, 4'h0, 6'd4, 32'h0);
    issue();
    checks++;
    if (rd(0) !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rdw_rf_a: got %h want 12345678", rd(0));
    end
    drv(1, 1'b0, 4'h0, 6'd4, 32'h0);
    issue();
    checks++;
    if (rd(1) !== 32'h1234_F00D) begin
      errors++;
      $display("FAIL rdw_rf_b_merge: got %h want 1234f00d", rd(1));
    end
    // Write then read on the very next cycle from the other port.
    drv(0, 1'b1, 4'hF, 6'd6, 32'h0BAD_F00D);
    do_cycle();
    idle();
    drv(1, 1'b0, 4'h0, 6'd6, 32'h0);
    issue();
    checks++;
    if (rd(1) !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL back_to_back: got %h want 0badf00d", rd(1));
    end
  endtask

  task automatic test_out_of_range();
    drv(2, 1'b1, 4'hF, 6'd50, 32'hDEAD_BEEF);
    issue();
    checks++;
    if (rv(2) !== 1'b0) begin
      errors++;
      $display("FAIL oor_write_rvalid: got %b want 0", rv(2));
    end
    drv(2, 1'b0, 4'h0, 6'd50, 32'h0);
    drv(3, 1'b0, 4'h0, 6'd2, 32'h0);
    issue();
    checks++;
    if ({rv(2), rd(2)} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL oor_read: got %b/%h want 1/00000000", rv(2), rd(2));
    end
    checks++;
    if ({rv(3), rd(3)} !== {1'b1, Init2}) begin
      errors++;
      $display("FAIL oor_alias: got %b/%h want 1/%h", rv(3), rd(3), Init2);
    end
  endtask

  task automatic test_rdw_write_first();
    drv(2, 1'b1, 4'hF, 6'd3, 32'hAAAA_AAAA);
    issue();
    drv(2, 1'b1, 4'hF, 6'd3, 32'h5555_5555);
    drv(3, 1'b0, 4'h0, 6'd3, 32'h0);
    issue();
    checks++;
    if ({rv(3), rd(3)} !== {1'b1, 32'h5555_5555}) begin
      errors++;
      $display("FAIL rdw_wf_b: got %b/%h want 1/55555555", rv(3), rd(3));
    end
    drv(3, 1'b1, 4'b0011, 6'd3, 32'h0000_BEEF);
    drv(2, 1'b0, 4'h0, 6'd3, 32'h0);
    issue();
    checks++;
    if ({rv(2), rd(2)} !== {1'b1, 32'h5555_BEEF}) begin
      errors++;
      $display("FAIL rdw_wf_a_merge: got %b/%h want 1/5555beef", rv(2), rd(2));
    end
  endtask

  task automatic test_clear();
    int n;
    clr = 1'b1;
    do_cycle();
    clr = 1'b0;
    repeat (10) do_cycle();
    clr = 1'b1;
    do_cycle();
    clr = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      do_cycle();
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL clr_restart_len: got %0d cycles want 64", n);
    end
    drv(0, 1'b0, 4'h0, 6'd5, 32'h0);
    issue();
    checks++;
    if ({rv(0), rd(0)} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL clr_contents: got %b/%h want 1/00000000", rv(0), rd(0));
    end
    drv(0, 1'b1, 4'hF, 6'd7, 32'h7777_7777);
    issue();
    drv(0, 1'b0, 4'h0, 6'd7, 32'h0);
    issue();
    clr = 1'b1;
    do_cycle();
    clr = 1'b0;
    repeat (20) do_cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, coll, rv(0), rd(0)} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: busy/coll/rvalid/rdata got %b/%b/%b/%h want 1/0/0/00000000",
               busy, coll, rv(0), rd(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      n++;
      do_cycle();
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL reset_restart_len: got %0d cycles want 64", n);
    end
    drv(1, 1'b0, 4'h0, 6'd7, 32'h0);
    issue();
    checks++;
    if ({rv(1), rd(1)} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_contents: got %b/%h want 1/00000000", rv(1), rd(1));
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_init();
    test_byte_enable();
    test_collision();
    test_rdw_read_first();
    test_out_of_range();
    test_rdw_write_first();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
